// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default widths,
// the index-width helper and the response tag carried down the pipeline.
package mult_share_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_DATA_IN_WIDTH  = 8;
  localparam int unsigned DEF_DATA_OUT_WIDTH = 8;
  localparam int unsigned DEF_TAKE_MSB       = 1;
  localparam int unsigned DEF_MULT_LATENCY   = 2;

  // Tag id field is sized for up to 256 requesters; the top truncates it.
  localparam int unsigned TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } resp_tag_t;

  // Ceiling log2 with a floor of 1 so single-value fields keep one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/multiplier_param.sv
// Combinational unsigned multiplier returning an MSB- or LSB-aligned slice.
module multiplier_param #(
  parameter int unsigned DATA_IN_WIDTH  = 8,
  parameter int unsigned DATA_OUT_WIDTH = 8,
  parameter int unsigned TAKE_MSB       = 1
) (
  input  logic [DATA_IN_WIDTH-1:0]  a,
  input  logic [DATA_IN_WIDTH-1:0]  b,
  output logic [DATA_OUT_WIDTH-1:0] y
);

  localparam int unsigned FULL_W = 2 * DATA_IN_WIDTH;
  localparam int unsigned SHIFT  = (TAKE_MSB != 0) ? (FULL_W - DATA_OUT_WIDTH) : 0;

  logic [FULL_W-1:0] full;

  assign full = FULL_W'(a) * FULL_W'(b);
  // Truncating the shifted product selects the slice; no rounding or saturation.
  assign y    = DATA_OUT_WIDTH'(full >> SHIFT);

endmodule

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter_onehot #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  // Scan distances 0..NUM_REQ-1 from ptr; the first requesting slot wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((32'(ptr) + k) % NUM_REQ) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin
// grants; results come back tagged with the originating requester.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int unsigned DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int unsigned TAKE_MSB       = DEF_TAKE_MSB,
  parameter int unsigned MULT_LATENCY   = DEF_MULT_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_en,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]     req_b,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [DATA_OUT_WIDTH-1:0]            resp_data,
  output logic [clog2(NUM_REQ)-1:0]            resp_id,
  output logic [clog2(MULT_LATENCY+1)-1:0]     inflight
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned INF_W = clog2(MULT_LATENCY + 1);

  logic [ID_W-1:0]           rr_ptr;
  logic [ID_W-1:0]           grant_idx;
  logic [NUM_REQ-1:0]        grant;
  logic                      accept;
  logic                      emit;
  logic [DATA_IN_WIDTH-1:0]  a_sel;
  logic [DATA_IN_WIDTH-1:0]  b_sel;
  logic [DATA_OUT_WIDTH-1:0] prod;
  resp_tag_t                 tag_q  [MULT_LATENCY];
  logic [DATA_OUT_WIDTH-1:0] data_q [MULT_LATENCY];
  resp_tag_t                 resp_tag;

  rr_arbiter_onehot #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = (rst || !issue_en) ? '0 : grant;
  assign accept    = |req_ready;

  // Operand mux and index encode from the one-hot grant.
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        a_sel     = req_a[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        b_sel     = req_b[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        grant_idx = ID_W'(i);
      end
    end
  end

  multiplier_param #(
    .DATA_IN_WIDTH  (DATA_IN_WIDTH),
    .DATA_OUT_WIDTH (DATA_OUT_WIDTH),
    .TAKE_MSB       (TAKE_MSB)
  ) u_mult (
    .a (a_sel),
    .b (b_sel),
    .y (prod)
  );

  // A response is emitted at the edge that loads the last stage with a valid op.
  if (MULT_LATENCY == 1) begin : g_emit_direct
    assign emit = accept;
  end else begin : g_emit_staged
    assign emit = tag_q[MULT_LATENCY-2].valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      inflight <= '0;
      for (int unsigned s = 0; s < MULT_LATENCY; s++) begin
        tag_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else begin
      if (accept) begin
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      inflight  <= inflight + INF_W'(accept) - INF_W'(emit);
      tag_q[0]  <= '{valid: accept, id: TAG_ID_W'(grant_idx)};
      data_q[0] <= prod;
      for (int unsigned s = 1; s < MULT_LATENCY; s++) begin
        tag_q[s]  <= tag_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end
  end

  assign resp_tag   = tag_q[MULT_LATENCY-1];
  assign resp_valid = resp_tag.valid ? (NUM_REQ'(1) << resp_tag.id) : '0;
  assign resp_data  = data_q[MULT_LATENCY-1];
  assign resp_id    = ID_W'(resp_tag.id);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench: three arbiter configurations (MSB/L2, LSB/L2, MSB/L1)
// share stimulus and are checked against a cycle-indexed accept history.
module tb_mult_share_arbiter;

  localparam int NR   = 4;
  localparam int MAXE = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic [3:0] rdy0, rdy1, rdy2;
  logic [3:0] rv0, rv1, rv2;
  logic [7:0] rd0, rd1, rd2;
  logic [1:0] id0, id1, id2;
  logic [1:0] inf0, inf1;
  logic       inf2;

  int checks = 0;
  int errors = 0;
  int rr, m, refill, last_acc;
  int hist_v  [MAXE];
  int hist_id [MAXE];
  int hist_p  [MAXE];

  always #5 clk = ~clk;

  mult_share_arbiter #(.TAKE_MSB(1), .MULT_LATENCY(2)) dut_msb (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy0), .resp_valid(rv0),
    .resp_data(rd0), .resp_id(id0), .inflight(inf0)
  );

  mult_share_arbiter #(.TAKE_MSB(0), .MULT_LATENCY(2)) dut_lsb (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy1), .resp_valid(rv1),
    .resp_data(rd1), .resp_id(id1), .inflight(inf1)
  );

  mult_share_arbiter #(.TAKE_MSB(1), .MULT_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy2), .resp_valid(rv2),
    .resp_data(rd2), .resp_id(id2), .inflight(inf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, m);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]     = 1'b1;
    req_a[i*8 +: 8]  = 8'(a);
    req_b[i*8 +: 8]  = 8'(b);
  endtask

  task automatic new_req(input int i);
    set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  // First valid requester scanning up from the round-robin pointer.
  function automatic int model_grant();
    int i;
    if (rst || !issue_en) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (rr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Check all configs between edges, then advance the model across the next edge.
  task automatic step();
    int g, lat, j, cnt;
    logic [31:0] g_rv, g_rd, g_id, g_inf, g_rdy, exp_d;
    @(negedge clk);
    g = model_grant();
    for (int c = 0; c < 3; c++) begin
      lat = (c == 2) ? 1 : 2;
      case (c)
        0:       begin g_rv = 32'(rv0); g_rd = 32'(rd0); g_id = 32'(id0); g_inf = 32'(inf0); g_rdy = 32'(rdy0); end
        1:       begin g_rv = 32'(rv1); g_rd = 32'(rd1); g_id = 32'(id1); g_inf = 32'(inf1); g_rdy = 32'(rdy1); end
        default: begin g_rv = 32'(rv2); g_rd = 32'(rd2); g_id = 32'(id2); g_inf = 32'(inf2); g_rdy = 32'(rdy2); end
      endcase
      j = m - lat + 1;
      if (j >= 0 && hist_v[j] != 0) begin
        exp_d = (c == 1) ? 32'(hist_p[j] % 256) : 32'(hist_p[j] / 256);
        check($sformatf("resp_valid_c%0d", c), g_rv, 32'(1) << hist_id[j]);
        check($sformatf("resp_data_c%0d", c), g_rd, exp_d);
        check($sformatf("resp_id_c%0d", c), g_id, 32'(hist_id[j]));
      end else begin
        check($sformatf("resp_idle_c%0d", c), g_rv, 32'(0));
      end
      cnt = 0;
      for (int e = j + 1; e <= m; e++) begin
        if (e >= 0 && hist_v[e] != 0) cnt++;
      end
      check($sformatf("inflight_c%0d", c), g_inf, 32'(cnt));
      check($sformatf("req_ready_c%0d", c), g_rdy, (g < 0) ? 32'(0) : (32'(1) << g));
    end
    m++;
    hist_v[m] = 0;
    last_acc  = -1;
    if (rst) begin
      for (int e = 0; e <= m; e++) hist_v[e] = 0;
      rr = 0;
    end else if (g >= 0) begin
      hist_v[m]  = 1;
      hist_id[m] = g;
      hist_p[m]  = int'(req_a[g*8 +: 8]) * int'(req_b[g*8 +: 8]);
      rr         = (g + 1) % NR;
      last_acc   = g;
    end
    @(posedge clk);
    #1;
    if (last_acc >= 0) begin
      if (refill == 1 || (refill == 2 && $urandom_range(0, 9) < 6)) new_req(last_acc);
      else req_valid[last_acc] = 1'b0;
    end
    if (refill == 2) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 3) new_req(i);
      end
      rst      = ($urandom_range(0, 99) < 2);
      issue_en = ($urandom_range(0, 99) < 85);
    end
  endtask

  initial begin
    rst       = 1'b1;
    issue_en  = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    refill    = 0;
    rr        = 0;
    m         = 0;
    last_acc  = -1;
    for (int e = 0; e < MAXE; e++) hist_v[e] = 0;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(rv0), 32'(0));
    check("rst_data", 32'(rd0), 32'(0));
    check("rst_id", 32'(id0), 32'(0));
    check("rst_inflight", 32'(inf0), 32'(0));
    check("rst_data_l1", 32'(rd2), 32'(0));
    step();

    // Single request from requester 2.
    rst = 1'b0;
    set_req(2, 200, 100);
    repeat (4) step();

    // Slice boundaries: 15x17 and 255x255.
    set_req(0, 15, 17);
    repeat (4) step();
    set_req(1, 255, 255);
    repeat (4) step();

    // Fairness with all requesters valid from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) new_req(i);
    refill = 1;
    repeat (12) step();
    refill = 0;
    repeat (6) step();

    // issue_en gating with one op in flight.
    set_req(0, 3, 4);
    step();
    set_req(1, 11, 12);
    set_req(3, 13, 14);
    issue_en = 1'b0;
    repeat (3) step();
    issue_en = 1'b1;
    repeat (4) step();

    // Reset right after two accepts.
    set_req(0, 250, 250);
    set_req(1, 128, 2);
    repeat (2) step();
    rst = 1'b1;
    step();
    set_req(3, 9, 9);
    set_req(2, 7, 7);
    step();
    rst = 1'b0;
    repeat (6) step();

    // Randomized traffic with occasional reset and issue_en drops.
    refill = 2;
    repeat (1500) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
